dump_readout_sequencer: RTL

//  Sequences readout of the capture sample RAM for a host dump. After capture, walks
//  the circular RAM from (trigger - pretrigger) for a programmed count of samples.

---
 rtl/dump_readout_sequencer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/dump_readout_sequencer.sv
// rtl/dump_readout_sequencer.sv - circular sample-RAM readout sequencer feeding the host dump FSM
// Optional trailing checksum word: define READOUT_CHECKSUM_EN.
module dump_readout_sequencer #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] trig_addr,
    input  logic [ADDR_W-1:0] pre_count,
    input  logic [ADDR_W:0]   total_count,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              has_return_data,
    output logic [DATA_W-1:0] return_data,
    input  logic              get_return_data,
    output logic              idle,
    output logic              done
);

    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   REM_ONE  = (ADDR_W + 1)'(1);

`ifdef READOUT_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_RD, S_HOLD, S_CSUM, S_FIN} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_RD, S_HOLD, S_FIN} state_t;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              has_q, has_d;
`ifdef READOUT_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              last_q, last_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            lat_q   <= '0;
            data_q  <= '0;
            has_q   <= 1'b0;
`ifdef READOUT_CHECKSUM_EN
            sum_q   <= '0;
            last_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            lat_q   <= lat_d;
            data_q  <= data_d;
            has_q   <= has_d;
`ifdef READOUT_CHECKSUM_EN
            sum_q   <= sum_d;
            last_q  <= last_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        lat_d     = lat_q;
        data_d    = data_q;
        has_d     = has_q;
`ifdef READOUT_CHECKSUM_EN
        sum_d     = sum_q;
        last_d    = last_q;
`endif
        mem_rd_en = 1'b0;
        done      = 1'b0;

        // abort wins over everything, including a start or a read returning this cycle
        if (abort) begin
            state_d = S_IDLE;
            has_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        addr_d = trig_addr - pre_count;
                        rem_d  = total_count;
`ifdef READOUT_CHECKSUM_EN
                        sum_d   = '0;
                        last_d  = 1'b0;
                        state_d = (total_count == '0) ? S_CSUM : S_ISSUE;
`else
                        state_d = (total_count == '0) ? S_FIN : S_ISSUE;
`endif
                    end
                end
                S_ISSUE: begin
                    mem_rd_en = 1'b1;
                    addr_d    = addr_q + ADDR_ONE;
                    rem_d     = rem_q - REM_ONE;
                    lat_d     = LAT_W'(MEM_LAT - 1);
                    state_d   = S_WAIT_RD;
                end
                S_WAIT_RD: begin
                    if (lat_q == '0) begin
                        data_d  = mem_rd_data;
                        has_d   = 1'b1;
                        state_d = S_HOLD;
                    end else begin
                        lat_d = lat_q - LAT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (get_return_data) begin
                        has_d = 1'b0;
`ifdef READOUT_CHECKSUM_EN
                        if (last_q) begin
                            state_d = S_FIN;
                        end else begin
                            sum_d   = sum_q + data_q;
                            state_d = (rem_q != '0) ? S_ISSUE : S_CSUM;
                        end
`else
                        state_d = (rem_q != '0) ? S_ISSUE : S_FIN;
`endif
                    end
                end
`ifdef READOUT_CHECKSUM_EN
                S_CSUM: begin
                    data_d  = sum_q;
                    has_d   = 1'b1;
                    last_d  = 1'b1;
                    state_d = S_HOLD;
                end
`endif
                S_FIN: begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign mem_rd_addr     = addr_q;
    assign has_return_data = has_q;
    assign return_data     = data_q;
    assign idle            = (state_q == S_IDLE);

endmodule
